// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory master and its helpers.
package lsu_pkg;

    localparam int unsigned DEF_MEM_WORDS   = 402;
    localparam int unsigned DEF_STATUS_WORD = 401;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

endpackage

// File: rtl/lsu_mem_master_load_ext.sv
// Sign/zero extension of the low-justified word returned by the data memory.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    always_comb begin
        data = raw;
        case (funct3)
            F3_B:    data = {{24{raw[7]}}, raw[7:0]};
            F3_H:    data = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   data = {24'h0, raw[7:0]};
            F3_HU:   data = {16'h0, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// CPU-side load/store initiator: one request at a time, checked, one memory
// access cycle, then a held valid/ready response.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = DEF_MEM_WORDS,
    parameter int unsigned STATUS_WORD = DEF_STATUS_WORD
) (
    input  logic        cpu_clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_dataW,
    output logic        mem_MEMRW,
    output logic [1:0]  mem_func3,
    input  logic [31:0] mem_dataR,
    output lsu_state_e  dbg_state
);

    // Handshakes: a request transfers on a clock edge where req_valid && req_ready;
    // a response transfers on an edge where resp_valid && resp_ready. resp_* are
    // held stable from the first resp_valid cycle until that transfer.

    localparam logic [29:0] MEM_WORDS_W   = MEM_WORDS[29:0];
    localparam logic [29:0] STATUS_WORD_W = STATUS_WORD[29:0];

    lsu_state_e  state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        req_err;
    logic [31:0] ext_data;

    always_comb begin
        req_err = 1'b0;
        case (req_funct3)
            F3_B, F3_BU: req_err = 1'b0;
            F3_H, F3_HU: req_err = req_addr[0];
            F3_W:        req_err = |req_addr[1:0];
            default:     req_err = 1'b1;
        endcase
        if (req_addr[31:2] >= MEM_WORDS_W) req_err = 1'b1;
        if (req_we && (req_addr[31:2] == STATUS_WORD_W)) req_err = 1'b1;
    end

    lsu_load_ext u_load_ext (
        .raw    (mem_dataR),
        .funct3 (f3_q),
        .data   (ext_data)
    );

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= F3_W;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        rdata_q <= '0;
                        err_q   <= req_err;
                        state   <= req_err ? RESP : ACCESS;
                    end
                end
                ACCESS: begin
                    // Loads capture the combinational memory output on this closing edge.
                    rdata_q <= we_q ? 32'h0 : ext_data;
                    state   <= RESP;
                end
                RESP: begin
                    if (resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_adr    = addr_q;
    assign mem_dataW  = wdata_q;
    assign mem_func3  = f3_q[1:0];
    assign mem_MEMRW  = (state == ACCESS) && we_q;
    assign dbg_state  = state;

endmodule
